// File: rtl/sgd_update_engine_if.sv
// ---------------------------------------------------------------------------
// sgd_update_engine_if
// Memory-side bus of the SGD weight-update engine: one shared read port
// feeding the four source BRAMs and the weight and previous-update write
// ports.
//   master : the engine. It drives the read and write addresses, the enables
//            and the write data, and receives the read data.
//   slave  : the BRAM side, with the opposite directions.
// Read data follows a 1-cycle latency and holds its value while rd_en is low.
// ---------------------------------------------------------------------------
interface sgd_update_engine_if #(
    parameter int ADDR_W = 12,
    parameter int ACC_W  = 32,
    parameter int W_W    = 16
);
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [ACC_W-1:0]  acc_pos_rd;
    logic [ACC_W-1:0]  acc_neg_rd;
    logic [W_W-1:0]    w_prev_upd_rd;
    logic [W_W-1:0]    w_rd;
    logic [ADDR_W-1:0] wr_addr;
    logic [W_W-1:0]    w_wr;
    logic              w_we;
    logic [W_W-1:0]    w_prev_upd_wr;
    logic              w_prev_we;

    modport master (
        output rd_addr, rd_en,
        input  acc_pos_rd, acc_neg_rd, w_prev_upd_rd, w_rd,
        output wr_addr, w_wr, w_we, w_prev_upd_wr, w_prev_we
    );

    modport slave (
        input  rd_addr, rd_en,
        output acc_pos_rd, acc_neg_rd, w_prev_upd_rd, w_rd,
        input  wr_addr, w_wr, w_we, w_prev_upd_wr, w_prev_we
    );
endinterface

// File: rtl/sgd_update_engine.sv
// ---------------------------------------------------------------------------
// sgd_update_engine
// Streams every element of one I_TILE x H_TILE weight tile through a
// momentum / weight-decay SGD update and writes the saturated results back.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             one-cycle pulse that begins a tile pass (taken in IDLE)
//   stall             freezes the FSM, the address counter and the pipeline
//   cfg_use_mom       enables the momentum term
//   cfg_use_wd        enables the weight-decay term
//   cfg_clr_mom       treats the previous update as zero for this pass
//   lr, mom, wd       unsigned Q0.CF_W coefficients, sampled at start
//   mem               BRAM bus (master side), see sgd_update_engine_if
//   busy              high from the accepted start until done
//   done              one-cycle pulse in the cycle after the final write
//   sat_cnt           number of clipped weights in the current/last pass
//
// Pipeline: S0 issues the address; S1 takes the BRAM data and forms the three
// products; S2 shifts, sums and saturates; the write is driven in the
// following cycle from the S2 registers (issue at t -> write at t+3).
// ---------------------------------------------------------------------------
module sgd_update_engine #(
    parameter int I_TILE   = 64,
    parameter int H_TILE   = 64,
    parameter int W_W      = 16,
    parameter int ACC_W    = 32,
    parameter int ACC_FRAC = 23,
    parameter int CF_W     = 16,
    parameter int ADDR_W   = $clog2(I_TILE * H_TILE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 cfg_use_mom,
    input  logic                 cfg_use_wd,
    input  logic                 cfg_clr_mom,
    input  logic [CF_W-1:0]      lr,
    input  logic [CF_W-1:0]      mom,
    input  logic [CF_W-1:0]      wd,
    sgd_update_engine_if.master  mem,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      sat_cnt
);
    localparam int N     = I_TILE * H_TILE;
    localparam int D_W   = ACC_W + 1;             // acc_pos - acc_neg never overflows
    localparam int PLR_W = D_W + CF_W + 1;        // lr*d; also the working sum width
    localparam int PW_W  = W_W + CF_W + 1;        // mom*prev and wd*w
    localparam int SH_LR = CF_W + ACC_FRAC - (W_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_reg, state_next;

    logic              armed_reg;                 // blocks a start coincident with reset release
    logic [ADDR_W-1:0] k_reg, k_next;
    logic              accept, issue;
    logic              use_mom_reg, use_wd_reg, clr_mom_reg;
    logic [CF_W-1:0]   lr_reg, mom_reg, wd_reg;

    // Pipeline registers
    logic                    v0_reg, v1_reg, v2_reg;
    logic [ADDR_W-1:0]       a0_reg, a1_reg, a2_reg;
    logic signed [PLR_W-1:0] prod_lr_reg;
    logic signed [PW_W-1:0]  prod_mom_reg, prod_wd_reg;
    logic signed [W_W-1:0]   w1_reg, w_new_reg, upd_sat_reg;

    // True when x is representable in W_W signed bits.
    function automatic logic fits_w(input logic signed [PLR_W-1:0] x);
        return (x[PLR_W-1:W_W-1] == {(PLR_W-W_W+1){x[W_W-1]}});
    endfunction

    function automatic logic signed [W_W-1:0] sat_w(input logic signed [PLR_W-1:0] x);
        if (fits_w(x))
            return x[W_W-1:0];
        else if (x[PLR_W-1])
            return {1'b1, {(W_W-1){1'b0}}};
        else
            return {1'b0, {(W_W-1){1'b1}}};
    endfunction

    // ---------------- FSM ----------------
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && armed_reg) begin
                    accept     = 1'b1;
                    k_next     = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue  = 1'b1;
                    k_next = k_reg + 1'b1;
                    if (k_reg == LAST_ADDR)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave in the cycle the last element is actually written, so
                // done lands right after it; a stalled write keeps us here.
                if (!stall && v2_reg && !v1_reg && !v0_reg)
                    state_next = DONE;
            end
            DONE: begin
                // The pipeline is empty here, so there is nothing for stall to
                // protect; always return so done stays a single-cycle pulse.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            armed_reg   <= 1'b0;
            k_reg       <= '0;
            use_mom_reg <= 1'b0;
            use_wd_reg  <= 1'b0;
            clr_mom_reg <= 1'b0;
            lr_reg      <= '0;
            mom_reg     <= '0;
            wd_reg      <= '0;
        end else begin
            state_reg <= state_next;
            armed_reg <= 1'b1;
            k_reg     <= k_next;
            if (accept) begin
                use_mom_reg <= cfg_use_mom;
                use_wd_reg  <= cfg_use_wd;
                clr_mom_reg <= cfg_clr_mom;
                lr_reg      <= lr;
                mom_reg     <= mom;
                wd_reg      <= wd;
            end
        end
    end

    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign done        = (state_reg == DONE);
    assign mem.rd_en   = issue;
    assign mem.rd_addr = k_reg;

    // ---------------- S1: difference and products ----------------
    logic signed [D_W-1:0]   d;
    logic signed [W_W-1:0]   prev;
    logic signed [PLR_W-1:0] prod_lr_next;
    logic signed [PW_W-1:0]  prod_mom_next, prod_wd_next;

    assign d = $signed({mem.acc_pos_rd[ACC_W-1], mem.acc_pos_rd})
             - $signed({mem.acc_neg_rd[ACC_W-1], mem.acc_neg_rd});
    assign prev          = clr_mom_reg ? '0 : $signed(mem.w_prev_upd_rd);
    assign prod_lr_next  = PLR_W'($signed({1'b0, lr_reg}))  * PLR_W'(d);
    assign prod_mom_next = PW_W'($signed({1'b0, mom_reg}))  * PW_W'(prev);
    assign prod_wd_next  = PW_W'($signed({1'b0, wd_reg}))   * PW_W'($signed(mem.w_rd));

    // ---------------- S2: shift, sum, saturate ----------------
    logic signed [PW_W-1:0]  mom_sh, wd_sh;
    logic signed [PLR_W-1:0] p_lr, p_mom, p_wd, upd, w_sum;
    logic signed [W_W-1:0]   upd_sat, w_new;
    logic                    clip;

    assign mom_sh  = prod_mom_reg >>> CF_W;
    assign wd_sh   = prod_wd_reg  >>> CF_W;
    assign p_lr    = prod_lr_reg  >>> SH_LR;
    assign p_mom   = use_mom_reg ? PLR_W'(mom_sh) : '0;
    assign p_wd    = use_wd_reg  ? PLR_W'(wd_sh)  : '0;
    assign upd     = p_lr + p_mom - p_wd;
    assign upd_sat = sat_w(upd);
    assign w_sum   = PLR_W'(w1_reg) + PLR_W'(upd_sat);
    assign w_new   = sat_w(w_sum);
    assign clip    = !fits_w(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_reg       <= 1'b0;
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            a0_reg       <= '0;
            a1_reg       <= '0;
            a2_reg       <= '0;
            prod_lr_reg  <= '0;
            prod_mom_reg <= '0;
            prod_wd_reg  <= '0;
            w1_reg       <= '0;
            w_new_reg    <= '0;
            upd_sat_reg  <= '0;
            sat_cnt      <= '0;
        end else begin
            if (accept)
                sat_cnt <= '0;
            if (!stall) begin
                v0_reg       <= issue;
                a0_reg       <= k_reg;
                v1_reg       <= v0_reg;
                a1_reg       <= a0_reg;
                prod_lr_reg  <= prod_lr_next;
                prod_mom_reg <= prod_mom_next;
                prod_wd_reg  <= prod_wd_next;
                w1_reg       <= $signed(mem.w_rd);
                v2_reg       <= v1_reg;
                a2_reg       <= a1_reg;
                w_new_reg    <= w_new;
                upd_sat_reg  <= upd_sat;
                if (v1_reg && clip && (sat_cnt != '1))
                    sat_cnt <= sat_cnt + 1'b1;
            end
        end
    end

    assign mem.wr_addr       = a2_reg;
    assign mem.w_wr          = w_new_reg;
    assign mem.w_prev_upd_wr = upd_sat_reg;
    assign mem.w_we          = v2_reg && !stall;
    assign mem.w_prev_we     = v2_reg && !stall;
endmodule

// File: tb/tb_sgd_update_engine.sv
// ---------------------------------------------------------------------------
// tb_sgd_update_engine
// Directed and randomized tile passes against an arithmetic reference model
// of the update rule; one line per pass plus a final summary.
// ---------------------------------------------------------------------------
module tb_sgd_update_engine;
    localparam int I_TILE   = 64;
    localparam int H_TILE   = 64;
    localparam int W_W      = 16;
    localparam int ACC_W    = 32;
    localparam int ACC_FRAC = 23;
    localparam int CF_W     = 16;
    localparam int N        = I_TILE * H_TILE;
    localparam int ADDR_W   = $clog2(N);
    localparam int BUDGET   = 20000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic            cfg_use_mom = 1'b0;
    logic            cfg_use_wd = 1'b0;
    logic            cfg_clr_mom = 1'b0;
    logic [CF_W-1:0] lr = '0;
    logic [CF_W-1:0] mom = '0;
    logic [CF_W-1:0] wd = '0;
    logic            busy;
    logic            done;
    logic [ADDR_W:0] sat_cnt;

    int checks = 0;
    int errors = 0;

    sgd_update_engine_if #(.ADDR_W(ADDR_W), .ACC_W(ACC_W), .W_W(W_W)) mem ();

    sgd_update_engine #(
        .I_TILE(I_TILE), .H_TILE(H_TILE), .W_W(W_W), .ACC_W(ACC_W),
        .ACC_FRAC(ACC_FRAC), .CF_W(CF_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .cfg_use_mom(cfg_use_mom), .cfg_use_wd(cfg_use_wd), .cfg_clr_mom(cfg_clr_mom),
        .lr(lr), .mom(mom), .wd(wd), .mem(mem),
        .busy(busy), .done(done), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- source BRAMs (1-cycle read, hold when idle) ----------
    logic [ACC_W-1:0] pos_mem [N];
    logic [ACC_W-1:0] neg_mem [N];
    logic [W_W-1:0]   prev_mem [N];
    logic [W_W-1:0]   w_mem [N];

    always @(posedge clk) begin
        if (mem.rd_en) begin
            mem.acc_pos_rd    <= pos_mem[mem.rd_addr];
            mem.acc_neg_rd    <= neg_mem[mem.rd_addr];
            mem.w_prev_upd_rd <= prev_mem[mem.rd_addr];
            mem.w_rd          <= w_mem[mem.rd_addr];
        end
    end

    // ---------------- write/issue log, sampled on the falling edge ---------
    int cyc = 0;
    int done_cnt = 0, done_since = -1, since_issue = 0;
    int next_wr = 0, order_err = 0, stall_viol = 0, we_pair_err = 0, wr_seen = 0;
    int wr_cnt [N];
    int iss_cyc [N];
    int wr_cyc [N];
    logic [W_W-1:0] wr_w [N];
    logic [W_W-1:0] wr_u [N];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (start && !busy && rst_n) begin
            for (int a = 0; a < N; a++) wr_cnt[a] <= 0;
            done_cnt    <= 0;
            done_since  <= -1;
            since_issue <= 0;
            next_wr     <= 0;
            order_err   <= 0;
            stall_viol  <= 0;
            we_pair_err <= 0;
            wr_seen     <= 0;
        end else begin
            if (mem.rd_en) begin
                iss_cyc[mem.rd_addr] <= cyc;
                since_issue <= 0;
            end else if (!stall) begin
                since_issue <= since_issue + 1;
            end
            if ((mem.rd_en || mem.w_we) && stall) stall_viol <= stall_viol + 1;
            if (mem.w_we !== mem.w_prev_we) we_pair_err <= we_pair_err + 1;
            if (mem.w_we) begin
                wr_cnt[mem.wr_addr] <= wr_cnt[mem.wr_addr] + 1;
                wr_w[mem.wr_addr]   <= mem.w_wr;
                wr_u[mem.wr_addr]   <= mem.w_prev_upd_wr;
                wr_cyc[mem.wr_addr] <= cyc;
                if (int'(mem.wr_addr) != next_wr) order_err <= order_err + 1;
                next_wr <= next_wr + 1;
                wr_seen <= wr_seen + 1;
            end
            if (done) begin
                done_cnt   <= done_cnt + 1;
                done_since <= since_issue;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint x, input longint m);
        longint q;
        q = x / m;
        if ((x % m != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint clamp(input longint x);
        longint lo, hi;
        hi = (longint'(1) << (W_W - 1)) - 1;
        lo = -(longint'(1) << (W_W - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    task automatic model(input int a, output logic [W_W-1:0] e_w,
                         output logic [W_W-1:0] e_u, output bit clip);
        longint d, prev, w, upd, u, s, wn;
        d    = longint'($signed(pos_mem[a])) - longint'($signed(neg_mem[a]));
        prev = cfg_clr_mom ? 0 : longint'($signed(prev_mem[a]));
        w    = longint'($signed(w_mem[a]));
        upd  = floor_div(longint'(lr) * d, longint'(1) << (CF_W + ACC_FRAC - (W_W - 1)));
        if (cfg_use_mom) upd = upd + floor_div(longint'(mom) * prev, longint'(1) << CF_W);
        if (cfg_use_wd)  upd = upd - floor_div(longint'(wd) * w, longint'(1) << CF_W);
        u    = clamp(upd);
        s    = w + u;
        wn   = clamp(s);
        clip = (wn != s);
        e_w  = W_W'(wn);
        e_u  = W_W'(u);
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic set_cfg(input logic [CF_W-1:0] l, input logic [CF_W-1:0] m,
                           input logic [CF_W-1:0] w, input bit um, input bit uw, input bit cm);
        lr = l; mom = m; wd = w;
        cfg_use_mom = um; cfg_use_wd = uw; cfg_clr_mom = cm;
    endtask

    // Element 0 carries the directed values, every other element is zero.
    task automatic fill_directed(input logic [ACC_W-1:0] p, input logic [W_W-1:0] pv,
                                 input logic [W_W-1:0] w);
        for (int a = 0; a < N; a++) begin
            pos_mem[a] = '0; neg_mem[a] = '0; prev_mem[a] = '0; w_mem[a] = '0;
        end
        pos_mem[0] = p; prev_mem[0] = pv; w_mem[0] = w;
    endtask

    task automatic fill_random();
        for (int a = 0; a < N; a++) begin
            pos_mem[a]  = ACC_W'($signed($urandom) >>> $urandom_range(0, 14));
            neg_mem[a]  = ACC_W'($signed($urandom) >>> $urandom_range(0, 14));
            prev_mem[a] = W_W'($urandom);
            w_mem[a]    = W_W'($urandom);
        end
    endtask

    task automatic run_pass(input string name, input int stall_pct, input bit poke_start);
        int c, bad, data_err, lat_err, exp_sat;
        logic [W_W-1:0] e_w, e_u;
        bit clip;
        @(posedge clk); #1;
        stall = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!done && c < BUDGET) begin
            stall = ($urandom_range(0, 99) < stall_pct);
            start = poke_start && ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        stall = 1'b0;
        check({name, "_no_timeout"}, longint'(c < BUDGET), 1);
        repeat (5) @(posedge clk);
        #1;
        bad = 0; data_err = 0; lat_err = 0; exp_sat = 0;
        for (int a = 0; a < N; a++) begin
            model(a, e_w, e_u, clip);
            if (wr_cnt[a] != 1) bad++;
            if (wr_w[a] !== e_w || wr_u[a] !== e_u) data_err++;
            if (wr_cyc[a] - iss_cyc[a] != 3) lat_err++;
            if (clip) exp_sat++;
        end
        if (exp_sat > (1 << (ADDR_W + 1)) - 1) exp_sat = (1 << (ADDR_W + 1)) - 1;
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_done_after_3"}, done_since, 3);
        check({name, "_write_once"}, bad, 0);
        check({name, "_write_order"}, order_err, 0);
        check({name, "_stall_rule"}, stall_viol, 0);
        check({name, "_we_pair"}, we_pair_err, 0);
        check({name, "_data"}, data_err, 0);
        check({name, "_sat_cnt"}, sat_cnt, exp_sat);
        check({name, "_idle_after"}, busy, 0);
        if (stall_pct == 0) check({name, "_latency3"}, lat_err, 0);
        $display("pass %s: writes=%0d sat_cnt=%0d expected_sat=%0d data_err=%0d",
                 name, wr_seen, sat_cnt, exp_sat, data_err);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c, seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_rd_en", mem.rd_en, 0);
        check("rst_w_we", {mem.w_we, mem.w_prev_we}, 0);
        check("rst_wr_data", {mem.wr_addr, mem.w_wr, mem.w_prev_upd_wr, mem.rd_addr}, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // lr * 1.0 -> +0.5 update on 0.125
        fill_directed(32'h0080_0000, 16'h0000, 16'h1000);
        set_cfg(16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_pass("lr", 0, 1'b0);
        check("lr_w_wr0", wr_w[0], 'h5000);
        check("lr_upd0", wr_u[0], 'h4000);

        // same update, weight clips at the positive bound
        fill_directed(32'h0080_0000, 16'h0000, 16'h7000);
        run_pass("lr_sat", 25, 1'b0);
        check("lr_sat_w_wr0", wr_w[0], 'h7FFF);
        check("lr_sat_cnt_one", sat_cnt, 1);

        // momentum only
        fill_directed(32'h0, 16'h2000, 16'h0000);
        set_cfg(16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_pass("mom", 25, 1'b0);
        check("mom_w_wr0", wr_w[0], 'h1000);
        check("mom_upd0", wr_u[0], 'h1000);

        // momentum with the previous update cleared
        set_cfg(16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_pass("mom_clr", 25, 1'b0);
        check("mom_clr_w_wr0", wr_w[0], 'h0000);

        // weight decay only
        fill_directed(32'h0, 16'h0000, 16'h2000);
        set_cfg(16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_pass("wd", 25, 1'b0);
        check("wd_upd0", wr_u[0], 'hF000);
        check("wd_w_wr0", wr_w[0], 'h1000);

        // random data, all terms, random stalls, stray starts while busy
        fill_random();
        set_cfg(CF_W'($urandom), CF_W'($urandom), CF_W'($urandom), 1'b1, 1'b1, 1'b0);
        run_pass("random", 30, 1'b1);

        // abort with reset while element 100 is being issued
        fill_random();
        set_cfg(CF_W'($urandom), CF_W'($urandom), CF_W'($urandom), 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (!(mem.rd_en && mem.rd_addr == ADDR_W'(100)) && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_reached_100", longint'(c < 1000), 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy_done", {busy, done}, 0);
        check("abort_enables", {mem.rd_en, mem.w_we, mem.w_prev_we}, 0);
        check("abort_buses", {mem.wr_addr, mem.w_wr, mem.w_prev_upd_wr, mem.rd_addr}, 0);
        check("abort_sat_cnt", sat_cnt, 0);
        seen = wr_seen;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        check("abort_no_writes", wr_seen, seen);
        $display("abort at element 100: writes_before=%0d", seen);

        // start coincident with reset release is ignored
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("release_start_ignored", busy, 0);

        // clean pass after the abort
        set_cfg(CF_W'($urandom), CF_W'($urandom), CF_W'($urandom), 1'b1, 1'b0, 1'b1);
        run_pass("after_abort", 20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sgd_update_engine.md
Name: sgd_update_engine

Overview:
- Streaming SGD weight-update engine for one I_TILE x H_TILE RBM weight tile.
- Walks every (i,h) element in order: reads CD accumulators, previous update and current weight from BRAM, computes the momentum/weight-decay update, and writes saturated results back.
- Sits after the CD accumulation stage and before weight DMA-out.
- Successor to the single-tile stub: parametrised formats, selectable modes, a real pipelined FSM with stall, and saturation telemetry.

Parameters:
- I_TILE, 64, visible units per tile.
- H_TILE, 64, hidden units per tile.
- W_W, 16, weight and update width, signed Q1.(W_W-1).
- ACC_W, 32, accumulator width, signed.
- ACC_FRAC, 23, accumulator fraction bits.
- CF_W, 16, coefficient width, unsigned Q0.CF_W.
- ADDR_W, $clog2(I_TILE*H_TILE), element address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  one-cycle pulse that begins a tile pass.
- stall  in  1  freezes the pipeline while high.
- cfg_use_mom  in  1  enables the momentum term.
- cfg_use_wd  in  1  enables the weight-decay term.
- cfg_clr_mom  in  1  treats prev_upd as 0 for this pass.
- lr  in  CF_W  learning rate.
- mom  in  CF_W  momentum coefficient.
- wd  in  CF_W  weight-decay coefficient.
- rd_addr  out  ADDR_W  shared read address.
- rd_en  out  1  read enable for all source BRAMs.
- acc_pos_rd  in  ACC_W  positive-phase accumulator.
- acc_neg_rd  in  ACC_W  negative-phase accumulator.
- w_prev_upd_rd  in  W_W  previous update.
- w_rd  in  W_W  current weight.
- wr_addr  out  ADDR_W  write address for both write ports.
- w_wr  out  W_W  new weight.
- w_we  out  1  weight write enable.
- w_prev_upd_wr  out  W_W  new update.
- w_prev_we  out  1  update write enable.
- busy  out  1  high from start accepted until done.
- done  out  1  one-cycle pulse after the final write.
- sat_cnt  out  ADDR_W+1  count of saturated w_new values this pass.

Behaviour:
- Interface: one clock, clk. rst is asynchronous, active-low.
- Reset state: all outputs 0, FSM in IDLE, counters cleared.
- Reset mid-pass aborts immediately. No done pulse, no further writes.
- BRAM contract: 1-cycle read latency; outputs hold their value when rd_en is low.
- FSM states:
  - IDLE: on start, sample cfg_* and lr/mom/wd into registers, clear sat_cnt, set busy, go to RUN.
  - RUN: each non-stalled cycle, drive rd_en=1 and rd_addr=k, then k++. After issuing N-1 (N=I_TILE*H_TILE), go to DRAIN.
  - DRAIN: wait until the pipeline is empty, then go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while busy is ignored. start coincident with reset release is ignored.
- Pipeline:
  - S0 issues the address.
  - S1 captures BRAM data; computes d = acc_pos - acc_neg (ACC_W+1 bits, no overflow) and the three products.
  - S2 shifts, sums and saturates.
  - Write occurs in the S3 cycle.
- Latency: element k issued at cycle t is written at t+3 with zero stalls; wr_addr = k.
- Stall: while stall=1, rd_en=0, w_we=0 and w_prev_we=0; all pipeline registers, the address counter and the FSM hold. Release resumes with no loss or duplication.
- Arithmetic, all shifts arithmetic (floor):
  - p_lr = (lr*d) >>> (CF_W+ACC_FRAC-(W_W-1)).
  - p_mom = (mom*prev) >>> CF_W, with prev=0 if cfg_clr_mom.
  - p_wd = (wd*w) >>> CF_W.
  - upd = p_lr + (use_mom ? p_mom : 0) - (use_wd ? p_wd : 0), computed at full width.
  - upd_sat = saturate(upd, W_W).
  - w_new = saturate(w + upd_sat, W_W).
  - w_wr = w_new; w_prev_upd_wr = upd_sat.
  - w_we and w_prev_we pulse together.
- sat_cnt increments when w_new clips at either bound; it saturates at its maximum and holds its value after done.

Test Plan:
- lr=0x8000, acc_pos=0x0080_0000, acc_neg=0, w=0x1000, mom/wd off -> upd 0x4000, w_wr 0x5000, written at issue+3.
- Same as above but w=0x7000 -> w_wr 0x7FFF, sat_cnt=1 at done.
- lr=0, mom=0x8000, prev=0x2000, use_mom=1, w=0 -> upd 0x1000, w_wr 0x1000. With cfg_clr_mom=1 -> w_wr 0x0000.
- lr=0, wd=0x8000, w=0x2000, use_wd=1 -> upd 0xF000 (-0x1000), w_wr 0x1000.
- Full 4096-element pass with random stall pattern -> each address written exactly once, in order, matching the reference model; done arrives exactly once, 3 non-stalled cycles after the last issue; start pulses while busy are ignored.
- Assert rst low at element 100 -> all outputs 0 within that cycle, no done pulse. A subsequent start performs a clean full pass.
